// File: rtl/mont_mult_cios_pkg.sv
// mont_pkg: shared defaults, carry width, index-width helper and FSM state enum for mont_mult_cios
package mont_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_MAX_WORDS = 64;
  localparam int DEF_LEN_W = 8;
  localparam int CARRY_W = 2 * DEF_WORD_W + 2;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, SUB, OUT} state_t;
  function automatic int carry_w(input int w);
    return 2 * w + 2;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mont_mult_cios_if.sv
// mont_mult_cios_if: operand/result stream bus; master = caller (md_start, len, num_1, num_2, modulus, n_prime), slave = multiplier (md_busy, mm_valid, mm_out, md_end)
interface mont_mult_cios_if
  import mont_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              md_start;
  logic [LEN_W-1:0]  len;
  logic [WORD_W-1:0] num_1;
  logic [WORD_W-1:0] num_2;
  logic [WORD_W-1:0] modulus;
  logic [WORD_W-1:0] n_prime;
  logic              md_busy;
  logic              mm_valid;
  logic [WORD_W-1:0] mm_out;
  logic              md_end;
  modport master (
    output md_start, len, num_1, num_2, modulus, n_prime,
    input  md_busy, mm_valid, mm_out, md_end
  );
  modport slave (
    input  md_start, len, num_1, num_2, modulus, n_prime,
    output md_busy, mm_valid, mm_out, md_end
  );
endinterface

// File: rtl/mont_mult_cios_mac.sv
// mont_word_mac: combinational word MAC {c_out, s} = t + a*b + q*m + c_in (ports t, a, b, q, m, c_in in; s, c_out out)
module mont_word_mac
  import mont_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [WORD_W-1:0]   t,
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  input  logic [WORD_W-1:0]   q,
  input  logic [WORD_W-1:0]   m,
  input  logic [2*WORD_W+1:0] c_in,
  output logic [WORD_W-1:0]   s,
  output logic [2*WORD_W+1:0] c_out
);
  localparam int CW = carry_w(WORD_W);
  logic [2*WORD_W-1:0] ab;
  logic [2*WORD_W-1:0] qm;
  logic [CW:0] full;
  assign ab = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
  assign qm = {{WORD_W{1'b0}}, q} * {{WORD_W{1'b0}}, m};
  assign full = {3'b0, ab} + {3'b0, qm} + {{(WORD_W + 3){1'b0}}, t} + {1'b0, c_in};
  assign s = full[WORD_W-1:0];
  assign c_out = {{(WORD_W - 1){1'b0}}, full[CW:WORD_W]};
endmodule

// File: rtl/mont_mult_cios.sv
// mont_mult_cios: word-serial CIOS Montgomery multiplier (clk, rst, bus = mont_mult_cios_if.slave); define MONT_FINAL_SUB_EN for the final conditional subtraction
module mont_mult_cios
  import mont_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int LEN_W     = DEF_LEN_W
) (
  input logic             clk,
  input logic             rst,
  mont_mult_cios_if.slave bus
);
  localparam int CW = carry_w(WORD_W);
  localparam int AW = idx_w(MAX_WORDS);
  localparam int TW = idx_w(MAX_WORDS + 1);
  state_t state, state_n;
  logic [WORD_W-1:0] a_buf [MAX_WORDS];
  logic [WORD_W-1:0] b_buf [MAX_WORDS];
  logic [WORD_W-1:0] m_buf [MAX_WORDS];
  logic [WORD_W-1:0] t_buf [MAX_WORDS+1];
  logic [LEN_W-1:0] len_r, i, j, len_m1, j_m1;
  logic [WORD_W-1:0] np_r, q_r, q_now, q, s, a_j, b_i, m_j, t_j, t_top, out_word;
  logic [CW-1:0] c, c_out;
  logic [2*WORD_W-1:0] top_sum;
  logic accept, last_j, last_w;
  assign accept = state == IDLE && bus.md_start && bus.len != '0 && bus.len <= LEN_W'(MAX_WORDS);
  assign len_m1 = len_r - LEN_W'(1);
  assign j_m1 = j - LEN_W'(1);
  assign last_j = j == len_r;
  assign last_w = j == len_m1;
  assign a_j = a_buf[j[AW-1:0]];
  assign b_i = b_buf[i[AW-1:0]];
  assign m_j = m_buf[j[AW-1:0]];
  assign t_j = t_buf[j[TW-1:0]];
  assign t_top = t_buf[len_r[TW-1:0]];
  assign q_now = (t_buf[0] + a_buf[0] * b_i) * np_r;
  assign q = j == '0 ? q_now : q_r;
  assign top_sum = {{WORD_W{1'b0}}, t_top} + c[2*WORD_W-1:0];
  mont_word_mac #(.WORD_W(WORD_W)) u_mac (
    .t(t_j), .a(a_j), .b(b_i), .q(q), .m(m_j), .c_in(c), .s(s), .c_out(c_out)
  );
`ifdef MONT_FINAL_SUB_EN
  localparam state_t AFTER_MUL = SUB;
  logic borrow, take_sub;
  logic [WORD_W-1:0] sub_m;
  logic [WORD_W:0] diff;
  assign sub_m = last_j ? '0 : m_j;
  assign diff = {1'b0, t_j} - {1'b0, sub_m} - {{WORD_W{1'b0}}, borrow};
  assign out_word = take_sub ? diff[WORD_W-1:0] : t_j;
`else
  localparam state_t AFTER_MUL = OUT;
  assign out_word = t_j;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    bus.md_busy = state != IDLE || accept;
    bus.mm_valid = state == OUT;
    bus.md_end = state == OUT && last_w;
    bus.mm_out = state == OUT ? out_word : '0;
    case (state)
      IDLE: state_n = accept ? (bus.len == LEN_W'(1) ? MUL : LOAD) : IDLE;
      LOAD: state_n = last_w ? MUL : LOAD;
      MUL: state_n = last_j && i == len_m1 ? AFTER_MUL : MUL;
`ifdef MONT_FINAL_SUB_EN
      SUB: state_n = last_j ? OUT : SUB;
`endif
      OUT: state_n = last_w ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      c <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          len_r <= bus.len;
          np_r <= bus.n_prime;
          a_buf[0] <= bus.num_1;
          b_buf[0] <= bus.num_2;
          m_buf[0] <= bus.modulus;
          for (int k = 0; k <= MAX_WORDS; k++) t_buf[k] <= '0;
          i <= '0;
          c <= '0;
          j <= bus.len == LEN_W'(1) ? '0 : LEN_W'(1);
`ifdef MONT_FINAL_SUB_EN
          borrow <= 1'b0;
`endif
        end
        LOAD: begin
          a_buf[j[AW-1:0]] <= bus.num_1;
          b_buf[j[AW-1:0]] <= bus.num_2;
          m_buf[j[AW-1:0]] <= bus.modulus;
          j <= last_w ? '0 : j + LEN_W'(1);
        end
        MUL: if (last_j) begin
          t_buf[len_m1[TW-1:0]] <= top_sum[WORD_W-1:0];
          t_buf[len_r[TW-1:0]] <= top_sum[2*WORD_W-1:WORD_W];
          c <= '0;
          j <= '0;
          i <= i == len_m1 ? '0 : i + LEN_W'(1);
        end else begin
          if (j == '0) q_r <= q_now;
          else t_buf[j_m1[TW-1:0]] <= s;
          c <= c_out;
          j <= j + LEN_W'(1);
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          borrow <= last_j ? 1'b0 : diff[WORD_W];
          take_sub <= last_j ? !diff[WORD_W] : take_sub;
          j <= last_j ? '0 : j + LEN_W'(1);
        end
`endif
        OUT: begin
`ifdef MONT_FINAL_SUB_EN
          borrow <= diff[WORD_W];
`endif
          j <= last_w ? '0 : j + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mult_cios.sv
// tb_mont_mult_cios: table-driven and golden-model checks of mont_mult_cios at WORD_W=8 and WORD_W=32
module tb_mont_mult_cios;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT8 = 5;
  localparam int LAT32 = 32;
`else
  localparam int LAT8 = 3;
  localparam int LAT32 = 27;
`endif
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] np;
    logic [7:0] exp;
  } vec8_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mont_mult_cios_if #(.WORD_W(8), .LEN_W(8)) i8 ();
  mont_mult_cios_if #(.WORD_W(32), .LEN_W(8)) i32 ();
  mont_mult_cios #(.WORD_W(8), .MAX_WORDS(4), .LEN_W(8)) d8 (.clk(clk), .rst(rst), .bus(i8.slave));
  mont_mult_cios #(.WORD_W(32), .MAX_WORDS(8), .LEN_W(8)) d32 (.clk(clk), .rst(rst), .bus(i32.slave));
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask
  function automatic logic [127:0] inv128(input logic [127:0] m);
    logic [127:0] x;
    x = m;
    for (int k = 0; k < 6; k++) x = x * (128'd2 - m * x);
    return x;
  endfunction
  function automatic logic [127:0] gold(input logic [127:0] a, input logic [127:0] b, input logic [127:0] m);
    logic [255:0] ab;
    logic [127:0] q;
    logic [259:0] sum;
    logic [128:0] t;
    ab = {128'd0, a} * {128'd0, b};
    q = ab[127:0] * (128'd0 - inv128(m));
    sum = {4'd0, ab} + {4'd0, {128'd0, q} * {128'd0, m}};
    t = sum[256:128];
`ifdef MONT_FINAL_SUB_EN
    return t >= {1'b0, m} ? t[127:0] - m : t[127:0];
`else
    return t[127:0];
`endif
  endfunction
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, input logic [7:0] np,
                     output logic [7:0] res, output int vcyc, output int ecyc);
    res = '0;
    vcyc = -1;
    ecyc = -1;
    @(negedge clk);
    i8.md_start = 1'b1;
    i8.len = 8'd1;
    i8.num_1 = a;
    i8.num_2 = b;
    i8.modulus = m;
    i8.n_prime = np;
    for (int k = 1; k < 40 && ecyc < 0; k++) begin
      @(negedge clk);
      i8.md_start = 1'b0;
      if (i8.mm_valid) begin
        res = i8.mm_out;
        if (vcyc < 0) vcyc = k;
      end
      if (i8.md_end) ecyc = k;
    end
  endtask
  task automatic op32(input logic [127:0] a, input logic [127:0] b, input logic [127:0] m, input logic [31:0] np,
                      input int poke, input int rst_at, output logic [127:0] res, output int ecyc, output int nv);
    res = '0;
    ecyc = -1;
    nv = 0;
    @(negedge clk);
    i32.md_start = 1'b1;
    i32.len = 8'd4;
    i32.num_1 = a[31:0];
    i32.num_2 = b[31:0];
    i32.modulus = m[31:0];
    i32.n_prime = np;
    for (int k = 1; k < 60 && ecyc < 0; k++) begin
      @(negedge clk);
      i32.md_start = k == poke;
      if (k < 4) begin
        i32.num_1 = a[32*k +: 32];
        i32.num_2 = b[32*k +: 32];
        i32.modulus = m[32*k +: 32];
      end else if (k == poke) begin
        i32.num_1 = 32'hdeadbeef;
        i32.num_2 = 32'h12345678;
        i32.modulus = 32'h0badf00d;
        i32.n_prime = 32'h5a5a5a5a;
      end
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_flags", {i32.md_busy, i32.mm_valid, i32.md_end}, 0);
        chk("rst_out", i32.mm_out, 0);
      end
      if (i32.mm_valid) begin
        if (nv < 4) res[32*nv +: 32] = i32.mm_out;
        nv++;
      end
      if (i32.md_end) ecyc = k;
    end
    i32.md_start = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec8_t vt[$];
    logic [7:0] r8;
    logic [127:0] a, b, m, r, inv;
    logic [31:0] np;
    int vc, ec, nv, cnt;
    vt.push_back({8'd5, 8'd7, 8'd13, 8'd59, 8'd1});
    vt.push_back({8'd12, 8'd12, 8'd13, 8'd59, 8'd3});
    vt.push_back({8'd0, 8'd7, 8'd13, 8'd59, 8'd0});
    vt.push_back({8'd1, 8'd1, 8'd13, 8'd59, 8'd3});
    vt.push_back({8'd12, 8'd1, 8'd13, 8'd59, 8'd10});
    vt.push_back({8'd126, 8'd126, 8'd127, 8'd129, 8'd64});
`ifdef MONT_FINAL_SUB_EN
    vt.push_back({8'd250, 8'd250, 8'd251, 8'd205, 8'd201});
`endif
    i8.md_start = 1'b0;
    i8.len = '0;
    i8.num_1 = '0;
    i8.num_2 = '0;
    i8.modulus = '0;
    i8.n_prime = '0;
    i32.md_start = 1'b0;
    i32.len = '0;
    i32.num_1 = '0;
    i32.num_2 = '0;
    i32.modulus = '0;
    i32.n_prime = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags8", {i8.md_busy, i8.mm_valid, i8.md_end}, 0);
    chk("reset_out8", i8.mm_out, 0);
    chk("reset_flags32", {i32.md_busy, i32.mm_valid, i32.md_end}, 0);
    chk("reset_out32", i32.mm_out, 0);
    foreach (vt[n]) begin
      op8(vt[n].a, vt[n].b, vt[n].m, vt[n].np, r8, vc, ec);
      chk($sformatf("vec%0d_out", n), r8, vt[n].exp);
      chk($sformatf("vec%0d_valid_cycle", n), vc, LAT8);
      chk($sformatf("vec%0d_end_cycle", n), ec, LAT8);
    end
    @(negedge clk);
    chk("busy_after_end", i8.md_busy, 0);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      i8.md_start = 1'b1;
      i8.len = t == 0 ? 8'd0 : 8'd5;
      chk($sformatf("bad_len%0d_busy", t), i8.md_busy, 0);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        i8.md_start = 1'b0;
        cnt += int'(i8.md_busy) + int'(i8.md_end);
      end
      chk($sformatf("bad_len%0d_quiet", t), cnt, 0);
    end
    for (int n = 0; n < 200; n++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      m[127] = 1'b0;
      m[0] = 1'b1;
      a = {$urandom, $urandom, $urandom, $urandom} % m;
      b = {$urandom, $urandom, $urandom, $urandom} % m;
      if (n == 0) b = m - 128'd1;
      inv = 128'd0 - inv128(m);
      np = inv[31:0];
      op32(a, b, m, np, -10, -10, r, ec, nv);
      chk($sformatf("rand%0d_res", n), r, gold(a, b, m));
      chk($sformatf("rand%0d_end_cycle", n), ec, LAT32);
      chk($sformatf("rand%0d_words", n), nv, 4);
    end
    m = {32'h7fffffff, 32'hffffffff, 32'hffffffff, 32'hffffff61};
    a = 128'h0123456789abcdef0fedcba987654321;
    b = 128'h13579bdf2468ace0fdb97531eca86420;
    inv = 128'd0 - inv128(m);
    np = inv[31:0];
    op32(a, b, m, np, 10, -10, r, ec, nv);
    chk("poke_res", r, gold(a, b, m));
    chk("poke_end_cycle", ec, LAT32);
    op32(a, b, m, np, -10, 10, r, ec, nv);
    chk("abort_no_end", ec, -1);
    chk("abort_no_valid", nv, 0);
    op32(b, a, m, np, -10, -10, r, ec, nv);
    chk("after_abort_res", r, gold(b, a, m));
    chk("after_abort_end_cycle", ec, LAT32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
